// File: rtl/cnn_pkg.sv
// Shared constants, types and lane helpers for the CNN post-accumulation datapath.
package cnn_pkg;

    localparam int DATA_W  = 18;
    localparam int N_LANES = 16;
    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'((1 << (DATA_W - 1)) - 1);

    typedef enum logic [1:0] {
        ACC,
        FIN,
        OUT
    } state_t;

    typedef logic [N_LANES*DATA_W-1:0] vec_t;

    // Extracts lane idx from a packed lane vector (lane 0 in the LSBs).
    function automatic logic [DATA_W-1:0] lane_get(input vec_t v, input int unsigned idx);
        return v[idx*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/bias_relu_sat_lane.sv
// One output-channel lane: bias add, ReLU, requantising right shift, saturation.
// Purely combinational; the accumulator and result registers live in the top.
module bias_relu_sat_lane #(
    parameter int DATA_W = 18,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 0
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [DATA_W-1:0] bias,
    output logic        [DATA_W-1:0] res
);

    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << (DATA_W - 1)) - 64'd1);

    logic signed [ACC_W-1:0] sum;
    logic        [ACC_W-1:0] relu;
    logic        [ACC_W-1:0] shifted;

    always_comb begin
        sum     = acc + ACC_W'(bias);
        relu    = sum[ACC_W-1] ? '0 : sum;
        // relu is non-negative here, so a logical shift equals the arithmetic one.
        shifted = relu >> SHIFT;
        res     = (shifted > SAT_MAX) ? SAT_MAX[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/layer_bias_relu_acc.sv
// Accumulates N_PASS partial-sum vectors per result, then adds bias, applies ReLU,
// shifts and saturates every lane and hands the vector downstream via valid/ready.
module layer_bias_relu_acc #(
    parameter int N_adder_tree = cnn_pkg::N_LANES,
    parameter int DATA_W       = cnn_pkg::DATA_W,
    parameter int N_PASS       = 4,
    parameter int ACC_W        = 24,
    parameter int SHIFT        = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_adder_tree*DATA_W-1:0] in_data,
    input  logic [N_adder_tree*DATA_W-1:0] bias,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_adder_tree*DATA_W-1:0] out_data,
    output logic                           busy
);

    localparam int CNT_W = (N_PASS > 1) ? $clog2(N_PASS) : 1;

    generate
        if (N_PASS < 1) begin : g_bad_npass
            $error("N_PASS must be at least 1");
        end
        if (ACC_W < DATA_W + $clog2(N_PASS) + 1) begin : g_bad_accw
            $error("ACC_W too narrow for N_PASS accumulations of DATA_W plus bias");
        end
        if (SHIFT < 0) begin : g_bad_shift
            $error("SHIFT must be non-negative");
        end
    endgenerate

    cnn_pkg::state_t               state_q, state_d;
    logic [CNT_W-1:0]              cnt_q;
    logic signed [ACC_W-1:0]       acc_q [N_adder_tree];
    logic [N_adder_tree*DATA_W-1:0] lane_res;
    logic                          accept;
    logic                          last_pass;

    assign accept    = in_valid && in_ready;
    assign last_pass = (cnt_q == CNT_W'(N_PASS - 1));
    assign busy      = (state_q != cnn_pkg::ACC) || (cnt_q != '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= cnn_pkg::ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            cnn_pkg::ACC: begin
                in_ready = 1'b1;
                if (in_valid && last_pass) begin
                    state_d = cnn_pkg::FIN;
                end
            end
            cnn_pkg::FIN: state_d = cnn_pkg::OUT;
            cnn_pkg::OUT: begin
                if (out_ready) begin
                    state_d = cnn_pkg::ACC;
                end
            end
            default: state_d = cnn_pkg::ACC;
        endcase
    end

    // NOTE: the accumulator array is flops, not RAM, so it is cleared by the async reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < N_adder_tree; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                cnt_q <= last_pass ? '0 : cnt_q + 1'b1;
                // The first pass of a result overwrites, so no separate clear cycle is needed.
                for (int i = 0; i < N_adder_tree; i++) begin
                    acc_q[i] <= ((cnt_q == '0) ? ACC_W'(0) : acc_q[i])
                                + ACC_W'(signed'(in_data[i*DATA_W +: DATA_W]));
                end
            end
            if (state_q == cnn_pkg::FIN) begin
                out_data  <= lane_res;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
        bias_relu_sat_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .SHIFT  (SHIFT)
        ) u_lane (
            .acc  (acc_q[g]),
            .bias (bias[g*DATA_W +: DATA_W]),
            .res  (lane_res[g*DATA_W +: DATA_W])
        );
    end

endmodule
